// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-width codes
// and request legality helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WIDTH_B = 4'd1;
  localparam logic [3:0] WIDTH_H = 4'd2;
  localparam logic [3:0] WIDTH_W = 4'd4;
  localparam logic [3:0] WIDTH_D = 4'd8;

  localparam int unsigned CNT_W = 4;

  function automatic logic width_legal(input logic [3:0] width, input int unsigned data_w);
    case (width)
      WIDTH_B, WIDTH_H, WIDTH_W: return 1'b1;
      WIDTH_D:                   return data_w == 64;
      default:                   return 1'b0;
    endcase
  endfunction

  // width[2:0]-1 yields the offset mask for 1/2/4 and wraps to 3'b111 for 8.
  function automatic logic misaligned(input logic [3:0] width, input logic [2:0] addr_lo);
    return (addr_lo & (width[2:0] - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational big-endian lane logic: byte-lane mask, store replication and
// load extraction. Sign extension of loads is built only with MEM_SIGN_EXT_EN.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(NB)
) (
  input  logic [3:0]        width_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [DATA_W-1:0] ld_raw_i,
  output logic [NB-1:0]     sel_o,
  output logic [DATA_W-1:0] st_data_o,
  output logic [DATA_W-1:0] ld_data_o
);

  logic sign_fill;
  logic field_msb;

`ifdef MEM_SIGN_EXT_EN
  assign sign_fill = signed_i & field_msb;
`else
  logic unused_signed;
  assign unused_signed = signed_i ^ field_msb;
  assign sign_fill     = 1'b0;
`endif

  always_comb begin : lanes
    int unsigned w;
    int unsigned o;
    int unsigned idx;
    w         = 32'(width_i);
    o         = 32'(offset_i);
    sel_o     = '0;
    st_data_o = '0;
    ld_data_o = '0;
    field_msb = 1'b0;
    // Lane k sits at bits [DATA_W-1-8k -: 8]; the field's MSB byte is lane o.
    for (int unsigned k = 0; k < NB; k++) begin
      sel_o[NB-1-k] = (k >= o) && (k < o + w);
      idx = (w == 0) ? 0 : (w - 1 - (k & (w - 1)));
      if (idx < NB) st_data_o[DATA_W-1-8*k -: 8] = st_data_i[8*idx +: 8];
    end
    for (int unsigned j = 0; j < NB; j++) begin
      if (j < w) begin
        idx = o + w - 1 - j;
        if (idx < NB) ld_data_o[8*j +: 8] = ld_raw_i[DATA_W-1-8*idx -: 8];
      end
    end
    if (w >= 1 && w <= NB) field_msb = ld_data_o[8*w-1];
    for (int unsigned j = 0; j < NB; j++) begin
      if (j >= w) ld_data_o[8*j +: 8] = {8{sign_fill}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP.
// Optional load sign extension is selected by MEM_SIGN_EXT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned ADDR_W      = 32,
  parameter  int unsigned WAIT_CYCLES = 1,
  localparam int unsigned NB          = DATA_W / 8,
  localparam int unsigned OFF_W       = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [3:0]        req_width_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_signed_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [NB-1:0]     sram_sel_o,
  output logic [DATA_W-1:0] sram_data_o,
  input  logic [DATA_W-1:0] sram_data_i
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               signed_q, signed_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         width_q, width_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NB-1:0]      lane_sel;
  logic [DATA_W-1:0]  lane_st_data;
  logic [DATA_W-1:0]  lane_ld_data;
  logic               in_access;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .width_i   (width_q),
    .offset_i  (addr_q[OFF_W-1:0]),
    .signed_i  (signed_q),
    .st_data_i (wdata_q),
    .ld_raw_i  (sram_data_i),
    .sel_o     (lane_sel),
    .st_data_o (lane_st_data),
    .ld_data_o (lane_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      width_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    width_d  = width_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          signed_d = req_signed_i;
          addr_d   = req_addr_i;
          width_d  = req_width_i;
          wdata_d  = req_data_i;
          rdata_d  = '0;
          if (!width_legal(req_width_i, DATA_W) || misaligned(req_width_i, req_addr_i[2:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = we_q ? '0 : lane_ld_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_access    = (state_q == ST_ACCESS);
  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_data_o  = rdata_q;
  assign resp_err_o   = err_q;
  assign sram_ce_o    = in_access;
  assign sram_we_o    = in_access & we_q;
  assign sram_addr_o  = in_access ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign sram_sel_o   = in_access ? lane_sel : '0;
  assign sram_data_o  = in_access ? lane_st_data : '0;

endmodule
